// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: state encoding, error codes and default init list shared by the sensor sequencer
package i2c_seq_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_WR_REG, S_WR_VAL, S_WR_STOP, S_READY, S_PTR, S_RD, S_RD_TAIL, S_ABORT
  } state_t;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_NACK = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam int INIT_MAX = 8;
  localparam logic [15:0] INIT_PAIRS [INIT_MAX] = '{
    16'h6B00, 16'h1C00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000
  };
endpackage

// File: rtl/i2c_init_rom.sv
// i2c_init_rom: index to {register, value} lookup for the sensor init list
module i2c_init_rom import i2c_seq_pkg::*; (
  input  logic [2:0] idx,
  output logic [7:0] addr,
  output logic [7:0] val
);
  // Pure table lookup so the init list can change without touching the sequencer
  always_comb {addr, val} = INIT_PAIRS[idx];
endmodule

// File: rtl/i2c_sensor_sequencer.sv
// i2c_sensor_sequencer: drives the byte-level I2C master through sensor init and burst-read frames
module i2c_sensor_sequencer import i2c_seq_pkg::*; #(
  parameter int N_READ = 14,
  parameter logic [7:0] READ_REG = 8'h3B,
  parameter int INIT_LEN = 2,
  parameter int TIMEOUT = 200000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                trigger,
  output logic                busy,
  output logic                ready,
  output logic                frame_valid,
  output logic [8*N_READ-1:0] frame_data,
  output logic                error,
  output logic [1:0]          err_code,
  output logic [7:0]          m_data_in,
  output logic                m_write_enable,
  output logic                m_read_enable,
  output logic                m_sync_reset,
  input  logic [7:0]          m_data_out,
  input  logic                m_queued,
  input  logic                m_data_valid,
  input  logic                m_nack,
  input  logic                m_stop
);
  localparam logic [3:0] ILEN = 4'(INIT_LEN);
  localparam logic [4:0] NR = 5'(N_READ);
  localparam logic [19:0] WD_MAX = 20'(TIMEOUT - 1);
  state_t state, state_q;
  logic [2:0] idx, rom_idx;
  logic [7:0] rom_addr, rom_val;
  logic [4:0] rd_q, rd_v;
  logic [8*N_READ-1:0] shadow;
  logic [19:0] wd, wd_cnt;
  logic stop_d, stop_rise, init_run, expire;
  assign busy = !(state inside {S_IDLE, S_READY});
  assign ready = state == S_READY;
  assign rom_idx = (state == S_WR_STOP) ? idx + 3'd1 : (state inside {S_WR_REG, S_WR_VAL}) ? idx : 3'd0;
  assign wd_cnt = (state != state_q) ? 20'd0 : wd;
  assign expire = busy && wd_cnt == WD_MAX;
  i2c_init_rom u_rom (.idx(rom_idx), .addr(rom_addr), .val(rom_val));
  // Stop edge detection and per-state watchdog that restarts whenever the state changes
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      wd <= '0;
      stop_d <= 1'b0;
      stop_rise <= 1'b0;
    end else begin
      state_q <= state;
      wd <= busy ? wd_cnt + 20'd1 : 20'd0;
      stop_d <= m_stop;
      stop_rise <= m_stop & ~stop_d;
    end
  // Sequencer FSM; each output is set on the transition that needs it
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      idx <= '0;
      rd_q <= '0;
      rd_v <= '0;
      shadow <= '0;
      init_run <= 1'b0;
      frame_valid <= 1'b0;
      frame_data <= '0;
      error <= 1'b0;
      err_code <= ERR_NONE;
      m_data_in <= '0;
      m_write_enable <= 1'b0;
      m_read_enable <= 1'b0;
      m_sync_reset <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      m_sync_reset <= 1'b0;
      if ((state inside {S_RD, S_RD_TAIL}) && m_data_valid && rd_v != NR) begin
        for (int k = 0; k < N_READ; k++) if (rd_v == 5'(k)) shadow[8*k +: 8] <= m_data_out;
        rd_v <= rd_v + 5'd1;
      end
      if (expire) begin
        state <= S_IDLE;
        init_run <= 1'b0;
        m_sync_reset <= 1'b1;
        m_write_enable <= 1'b0;
        m_read_enable <= 1'b0;
        error <= 1'b1;
        err_code <= ERR_TIMEOUT;
      end else if (busy && state != S_ABORT && m_nack) begin
        state <= S_ABORT;
        m_write_enable <= 1'b0;
        m_read_enable <= 1'b0;
        error <= 1'b1;
        err_code <= ERR_NACK;
      end else begin
        case (state)
          S_IDLE, S_READY:
            if (start) begin
              state <= S_WR_REG;
              idx <= '0;
              init_run <= 1'b1;
              m_data_in <= rom_addr;
              m_write_enable <= 1'b1;
              error <= 1'b0;
              err_code <= ERR_NONE;
            end else if (trigger && state == S_READY) begin
              state <= S_PTR;
              m_data_in <= READ_REG;
              m_write_enable <= 1'b1;
              error <= 1'b0;
              err_code <= ERR_NONE;
            end
          S_WR_REG:
            if (m_queued) begin
              state <= S_WR_VAL;
              m_data_in <= rom_val;
            end
          S_WR_VAL:
            if (m_queued) begin
              state <= S_WR_STOP;
              m_write_enable <= 1'b0;
            end
          S_WR_STOP:
            if (stop_rise) begin
              if ({1'b0, idx} + 4'd1 < ILEN) begin
                idx <= idx + 3'd1;
                state <= S_WR_REG;
                m_data_in <= rom_addr;
                m_write_enable <= 1'b1;
              end else begin
                state <= S_READY;
                init_run <= 1'b0;
              end
            end
          S_PTR:
            if (m_queued) begin
              state <= S_RD;
              m_write_enable <= 1'b0;
              m_read_enable <= 1'b1;
              rd_q <= '0;
              rd_v <= '0;
            end
          S_RD: begin
            if (m_queued) rd_q <= rd_q + 5'd1;
            if (rd_q == NR) begin
              m_read_enable <= 1'b0;
              state <= S_RD_TAIL;
            end
          end
          S_RD_TAIL:
            if (stop_rise) begin
              state <= S_READY;
              if (rd_v == NR) begin
                frame_data <= shadow;
                frame_valid <= 1'b1;
              end else begin
                error <= 1'b1;
                err_code <= ERR_NACK;
              end
            end
          S_ABORT:
            if (stop_rise) begin
              state <= init_run ? S_IDLE : S_READY;
              init_run <= 1'b0;
            end
          default: state <= S_IDLE;
        endcase
      end
    end
endmodule
